bram_mmio_banked: RTL and testbench

Parametrised successor of the single-port byte-lane BRAM slave. Memory depth, data width, base address and init image are generic. Adds a valid/ready request port, a one-cycle registered response with error flag, and proper word indexing. Includes a hardware zero-fill sequencer so software or the boot FSM can clear scratch RAM. Sits on the CPU memory bus beside the other MMIO slaves.

---
 rtl/bram_mmio_pkg.sv | 23 ++
 rtl/bram_mmio_banked_lane.sv | 25 ++
 rtl/bram_mmio_banked.sv | 135 +++++++++++++
 tb/tb_bram_mmio_banked.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_mmio_pkg.sv
// Shared types and helpers for the banked BRAM MMIO slave.
// Optional feature macro used by the slave: BRAM_MMIO_CLEAR_EN.
package bram_mmio_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   localparam logic [1023:0] RSP_ERR_DATA = '0;

   // 33-bit compare so base + span cannot wrap at the top of the address map
   function automatic logic in_range(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [32:0] bytes);
      logic [32:0] a;
      logic [32:0] b;
      a = {1'b0, addr};
      b = {1'b0, base};
      return (a >= b) && (a < (b + bytes));
   endfunction

endpackage

// File: rtl/bram_mmio_banked_lane.sv
// One byte-wide bank: write enable, word index, registered read that holds when not enabled.
// INIT_FILE is accepted for interface compatibility; contents are established by writes or the sweep.
module bram_lane #(
   parameter int DEPTH_WORDS = 128,
   parameter int IDX_W       = 7,
   parameter int DATA_WIDTH  = 32,
   parameter int LANE        = 0,
   parameter     INIT_FILE   = ""
) (
   input  logic             clk,
   input  logic             we,
   input  logic             re,
   input  logic [IDX_W-1:0] idx,
   input  logic [7:0]       wdata,
   output logic [7:0]       rdata
);

   logic [7:0] mem [DEPTH_WORDS];

   always @(posedge clk) begin
      if (we) mem[idx] <= wdata;
      if (re) rdata <= mem[idx];
   end

endmodule

// File: rtl/bram_mmio_banked.sv
// Banked byte-lane BRAM MMIO slave: valid/ready request, 1-cycle registered response, error on out-of-range.
// BRAM_MMIO_CLEAR_EN adds a zero-fill sweep (on reset and on clear_start) that stalls requests while busy.
module bram_mmio_banked
   import bram_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_MEMORY = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 128,
   parameter int          DATA_WIDTH  = 32,
   parameter              INIT_FILE   = ""
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [31:0]             req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_be,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   input  logic                    clear_start,
   output logic                    busy
);

   localparam int          NBYTES = DATA_WIDTH / 8;
   localparam int          IDX_W  = $clog2(DEPTH_WORDS);
   localparam int          LANE_W = $clog2(NBYTES);
   localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) * 33'(NBYTES);

   state_e             state;
   logic [IDX_W-1:0]   clr_idx;

`ifdef BRAM_MMIO_CLEAR_EN
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

   state_e             state_nxt;
   logic [IDX_W-1:0]   clr_idx_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_CLEAR;
         clr_idx <= '0;
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      case (state)
         ST_RUN: begin
            if (clear_start) begin
               state_nxt   = ST_CLEAR;
               clr_idx_nxt = '0;
            end
         end
         ST_CLEAR: begin
            // clear_start is deliberately not looked at here: a sweep is never restarted
            clr_idx_nxt = clr_idx + 1'b1;
            if (clr_idx == LAST_IDX) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   assign req_ready = (state == ST_RUN) && !clear_start;
`else
   logic unused_clear_start;
   assign unused_clear_start = clear_start;
   assign state     = ST_RUN;
   assign clr_idx   = '0;
   assign req_ready = 1'b1;
`endif

   assign busy = (state == ST_CLEAR);

   logic                  accept;
   logic                  hit;
   logic                  rd_en;
   logic                  wr_en;
   logic                  rd_sel;
   logic [31:0]           offset;
   logic [IDX_W-1:0]      req_idx;
   logic [IDX_W-1:0]      ram_idx;
   logic [DATA_WIDTH-1:0] lane_q;

   assign accept  = req_valid && req_ready;
   assign hit     = in_range(req_addr, BASE_MEMORY, SPAN);
   assign offset  = req_addr - BASE_MEMORY;
   assign req_idx = IDX_W'(offset >> LANE_W);
   assign ram_idx = busy ? clr_idx : req_idx;
   assign rd_en   = accept && !req_write && hit;
   assign wr_en   = accept && req_write && hit;

   generate
      for (genvar i = 0; i < NBYTES; i++) begin : g_lane
         bram_lane #(
            .DEPTH_WORDS(DEPTH_WORDS),
            .IDX_W      (IDX_W),
            .DATA_WIDTH (DATA_WIDTH),
            .LANE       (i),
            .INIT_FILE  (INIT_FILE)
         ) u_lane (
            .clk  (clk),
            .we   (busy || (wr_en && req_be[i])),
            .re   (rd_en),
            .idx  (ram_idx),
            .wdata(busy ? 8'h00 : req_wdata[8*i +: 8]),
            .rdata(lane_q[8*i +: 8])
         );
      end
   endgenerate

   // rd_sel remembers whether the last response came from the array; the lane
   // registers only load on reads, so both hold between accepted requests
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rd_sel    <= 1'b0;
      end else begin
         rsp_valid <= accept;
         if (accept) begin
            rsp_err <= !hit;
            rd_sel  <= !req_write && hit;
         end
      end
   end

   assign rsp_rdata = rd_sel ? lane_q : DATA_WIDTH'(RSP_ERR_DATA);

endmodule

// File: tb/tb_bram_mmio_banked.sv
// Directed bench for bram_mmio_banked (BASE_MEMORY = 0x1000, 128 x 32-bit); follows BRAM_MMIO_CLEAR_EN.
module tb_bram_mmio_banked;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        clear_start = 1'b0;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bram_mmio_banked #(
      .BASE_MEMORY(32'h0000_1000),
      .DEPTH_WORDS(128),
      .DATA_WIDTH (32),
      .INIT_FILE  ("")
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .clear_start(clear_start),
      .busy       (busy)
   );

   // Issues one request from a negedge, waits (bounded) for ready, returns the
   // response sampled at the negedge after the accepting edge.
   task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] rd, output logic er,
                         output logic vld, output logic ok);
      int n = 0;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
      #1;
      while (!req_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      ok = (n < 400);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rd = rsp_rdata; er = rsp_err; vld = rsp_valid;
   endtask

   task automatic test_reset;
      int cnt;
      logic [31:0] rd; logic er, vld, ok;
      #2;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
`ifdef BRAM_MMIO_CLEAR_EN
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_sweep got %b want 0", req_ready); end
      cnt = 0;
      while (busy && cnt < 300) begin
         cnt++;
         @(negedge clk);
      end
      checks++; if (cnt != 128) begin errors++; $display("FAIL reset_sweep_len got %0d want 128", cnt); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", req_ready); end
      do_req(1'b0, 32'h0000_11FC, 32'h0, 4'h0, rd, er, vld, ok);
      checks++; if (!ok || vld !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin
         errors++; $display("FAIL reset_read_zero got ok=%b vld=%b err=%b data=%h want 1 1 0 00000000", ok, vld, er, rd);
      end
`else
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
      @(negedge clk);
`endif
   endtask

   task automatic test_byte_lane;
      logic [31:0] rd; logic er, vld, ok;
      do_req(1'b1, 32'h0000_1010, 32'hDEAD_BEEF, 4'b1111, rd, er, vld, ok);
      checks++; if (!ok || vld !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin
         errors++; $display("FAIL lane_write_rsp got ok=%b vld=%b err=%b data=%h want 1 1 0 00000000", ok, vld, er, rd);
      end
      #1;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL lane_pulse_hi got %b want 1", rsp_valid); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lane_pulse_lo got %b want 0", rsp_valid); end
      do_req(1'b0, 32'h0000_1010, 32'h0, 4'h0, rd, er, vld, ok);
      checks++; if (vld !== 1'b1 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL lane_read_full got vld=%b err=%b data=%h want 1 0 deadbeef", vld, er, rd);
      end
      do_req(1'b1, 32'h0000_1010, 32'h0000_5500, 4'b0010, rd, er, vld, ok);
      do_req(1'b0, 32'h0000_1010, 32'h0, 4'h0, rd, er, vld, ok);
      checks++; if (vld !== 1'b1 || er !== 1'b0 || rd !== 32'hDEAD_55EF) begin
         errors++; $display("FAIL lane_read_partial got vld=%b err=%b data=%h want 1 0 dead55ef", vld, er, rd);
      end
   endtask

   task automatic test_alias;
      logic [31:0] rd; logic er, vld, ok;
      logic [31:0] addrs [3];
      logic [31:0] exps [3];
      addrs = '{32'h0000_1004, 32'h0000_1006, 32'h0000_1008};
      exps  = '{32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h5555_5555};
      do_req(1'b1, 32'h0000_1004, 32'hAAAA_AAAA, 4'hF, rd, er, vld, ok);
      do_req(1'b1, 32'h0000_1008, 32'h5555_5555, 4'hF, rd, er, vld, ok);
      for (int i = 0; i < 3; i++) begin
         do_req(1'b0, addrs[i], 32'h0, 4'h0, rd, er, vld, ok);
         checks++; if (vld !== 1'b1 || er !== 1'b0 || rd !== exps[i]) begin
            errors++; $display("FAIL alias_read_%h got vld=%b err=%b data=%h want 1 0 %h", addrs[i], vld, er, rd, exps[i]);
         end
      end
   endtask

   task automatic test_out_of_range;
      logic [31:0] rd; logic er, vld, ok;
      do_req(1'b1, 32'h0000_1000, 32'h0BAD_F00D, 4'hF, rd, er, vld, ok);
      do_req(1'b1, 32'h0000_11FC, 32'h1234_5678, 4'hF, rd, er, vld, ok);
      do_req(1'b1, 32'h0000_0FFC, 32'hFFFF_FFFF, 4'hF, rd, er, vld, ok);
      checks++; if (vld !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
         errors++; $display("FAIL oor_write_low got vld=%b err=%b data=%h want 1 1 00000000", vld, er, rd);
      end
      do_req(1'b1, 32'h0000_1200, 32'hFFFF_FFFF, 4'hF, rd, er, vld, ok);
      checks++; if (vld !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
         errors++; $display("FAIL oor_write_high got vld=%b err=%b data=%h want 1 1 00000000", vld, er, rd);
      end
      do_req(1'b0, 32'h0000_1200, 32'h0, 4'h0, rd, er, vld, ok);
      checks++; if (vld !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
         errors++; $display("FAIL oor_read_high got vld=%b err=%b data=%h want 1 1 00000000", vld, er, rd);
      end
      do_req(1'b0, 32'h0000_11FC, 32'h0, 4'h0, rd, er, vld, ok);
      checks++; if (vld !== 1'b1 || er !== 1'b0 || rd !== 32'h1234_5678) begin
         errors++; $display("FAIL oor_last_word got vld=%b err=%b data=%h want 1 0 12345678", vld, er, rd);
      end
      do_req(1'b0, 32'h0000_1000, 32'h0, 4'h0, rd, er, vld, ok);
      checks++; if (er !== 1'b0 || rd !== 32'h0BAD_F00D) begin
         errors++; $display("FAIL oor_first_word got err=%b data=%h want 0 0badf00d", er, rd);
      end
   endtask

   task automatic test_back_to_back;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_1020;
      req_wdata = 32'hCAFE_BABE; req_be = 4'hF;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", req_ready); end
      @(posedge clk);
      #1 req_write = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL b2b_write_rsp got vld=%b data=%h want 1 00000000", rsp_valid, rsp_rdata);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFE_BABE) begin
         errors++; $display("FAIL b2b_read_rsp got vld=%b err=%b data=%h want 1 0 cafebabe", rsp_valid, rsp_err, rsp_rdata);
      end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hCAFE_BABE) begin
         errors++; $display("FAIL b2b_hold got vld=%b data=%h want 0 cafebabe", rsp_valid, rsp_rdata);
      end
   endtask

   task automatic test_clear;
`ifdef BRAM_MMIO_CLEAR_EN
      int cnt;
      logic [31:0] rd; logic er, vld, ok;
      logic [31:0] addrs [3];
      addrs = '{32'h0000_1000, 32'h0000_1004, 32'h0000_11FC};
      for (int i = 0; i < 3; i++) do_req(1'b1, addrs[i], 32'hFFFF_FFFF, 4'hF, rd, er, vld, ok);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_1000; clear_start = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL clear_beats_req got %b want 0", req_ready); end
      @(posedge clk);
      #1 begin clear_start = 1'b0; req_valid = 1'b0; end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL clear_no_accept got %b want 0", rsp_valid); end
      cnt = 0;
      while (busy && cnt < 300) begin
         cnt++;
         clear_start = (cnt == 60);
         @(negedge clk);
      end
      clear_start = 1'b0;
      checks++; if (cnt != 128) begin errors++; $display("FAIL clear_sweep_len got %0d want 128", cnt); end
      for (int i = 0; i < 3; i++) begin
         do_req(1'b0, addrs[i], 32'h0, 4'h0, rd, er, vld, ok);
         checks++; if (!ok || vld !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL clear_read_%h got ok=%b vld=%b data=%h want 1 1 00000000", addrs[i], ok, vld, rd);
         end
      end
`else
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_1010; clear_start = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL clear_ignored got ready=%b busy=%b want 1 0", req_ready, busy);
      end
      @(posedge clk);
      #1 begin clear_start = 1'b0; req_valid = 1'b0; end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_55EF) begin
         errors++; $display("FAIL clear_ignored_read got vld=%b data=%h want 1 dead55ef", rsp_valid, rsp_rdata);
      end
`endif
   endtask

   task automatic test_reset_mid_sweep;
      logic [31:0] rd; logic er, vld, ok;
`ifdef BRAM_MMIO_CLEAR_EN
      int cnt;
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      repeat (49) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL mid_reset got vld=%b busy=%b want 0 1", rsp_valid, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      while (busy && cnt < 300) begin
         cnt++;
         @(negedge clk);
      end
      checks++; if (cnt != 128) begin errors++; $display("FAIL mid_reset_sweep_len got %0d want 128", cnt); end
      do_req(1'b0, 32'h0000_1020, 32'h0, 4'h0, rd, er, vld, ok);
      checks++; if (!ok || rd !== 32'h0) begin errors++; $display("FAIL mid_reset_read got ok=%b data=%h want 1 00000000", ok, rd); end
`else
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_1010;
      @(posedge clk);
      #1 req_valid = 1'b0;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b want 1", rsp_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL async_reset got vld=%b data=%h want 0 00000000", rsp_valid, rsp_rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", req_ready); end
      @(negedge clk);
      do_req(1'b0, 32'h0000_1010, 32'h0, 4'h0, rd, er, vld, ok);
      checks++; if (vld !== 1'b1 || rd !== 32'hDEAD_55EF) begin
         errors++; $display("FAIL post_reset_retain got vld=%b data=%h want 1 dead55ef", vld, rd);
      end
`endif
   endtask

   initial begin
      test_reset;
      test_byte_lane;
      test_alias;
      test_out_of_range;
      test_back_to_back;
      test_clear;
      test_reset_mid_sweep;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
